vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates the raster timing that feeds the VGA pipeline: horizontal/vertical sync, pixel position counters and data-enable. It sits at the head of the video path, upstream of the pipeline register stages. It starts and stops cleanly on frame boundaries under a single run request. All timing is set by parameters, and all outputs are registered.

## Interface
- WIDTH, 10: width of the position counters; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal phase lengths in clocks; H_TOTAL = sum = 800.
- V_ACTIVE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical phase lengths in lines; V_TOTAL = sum = 525.
- SYNC_POL, 0: asserted sync level (0 = active-low pulses); the idle level is ~SYNC_POL.
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset; asynchronous and active-low.
- en  in  1  run request, sampled on clk.
- out_hsync  out  1  horizontal sync.
- out_vsync  out  1  vertical sync.
- out_hdata  out  WIDTH  horizontal position, 0..H_TOTAL-1.
- out_vdata  out  WIDTH  vertical position, 0..V_TOTAL-1.
- out_de  out  1  active-video enable.
- out_frame_start  out  1  one-clock pulse at position (0,0).
- out_line_start  out  1  one-clock pulse at every h = 0.
- out_running  out  1  high in RUN and STOPPING.

## Operation
- Control FSM states:
  - IDLE: counters held at 0; outputs at idle values.
  - IDLE→RUN when en = 1 is sampled.
  - RUN→STOPPING when en = 0 is sampled.
  - STOPPING→RUN when en = 1 is sampled (seamless; no timing disturbance).
  - STOPPING→IDLE at the edge where the position would wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Horizontal counter h:
  - increments every clock in RUN/STOPPING;
  - wraps H_TOTAL-1→0; each wrap increments the vertical counter v.
  - v wraps V_TOTAL-1→0.
- Phase FSM per axis: ACTIVE→FRONT→SYNC→BACK→ACTIVE.
  - Boundaries for h: ACTIVE [0,H_ACTIVE), FRONT [H_ACTIVE,H_ACTIVE+H_FRONT), SYNC [..,+H_SYNC), BACK [..,H_TOTAL).
  - The vertical axis uses the same scheme in lines.
  - The vertical phase changes only at h wrap.
- Output decode:
  - out_hsync = SYNC_POL while the h phase is SYNC; out_vsync likewise for the v phase.
  - out_de = (h phase ACTIVE) AND (v phase ACTIVE).
  - out_hdata/out_vdata = h/v.
  - out_line_start = (h == 0); out_frame_start = (h == 0 && v == 0).
- Reset values, and values in IDLE:
  - hsync/vsync = ~SYNC_POL;
  - hdata = vdata = 0;
  - de = frame_start = line_start = running = 0.
- Reset is asynchronous and may occur mid-frame: all state and outputs go to reset values immediately. Counting does not restart until en = 1 is sampled after rst_n deasserts.

## Timing
- Start latency: en sampled 1 at edge k → at edge k the outputs show (0,0) with out_de = 1, out_frame_start = 1, out_line_start = 1, out_running = 1.
- Position advances one pixel per clock; one frame = H_TOTAL × V_TOTAL = 420000 clocks at the defaults.
- Default sync windows:
  - hsync asserted for h = 656..751;
  - vsync asserted for v = 490..491, on all h of those lines;
  - vsync edges coincide with the h = 0 edge.
- Stop: en sampled 0 at any point → the current frame completes. On the edge after position (799,524), outputs take idle values and out_running = 0.
- en toggling 0→1 within the same frame: no visible effect on any timing output.

## Test plan
- Reset then idle: rst_n = 0, then release with en = 0 for 100 clocks → hsync = vsync = 1, de = 0, hdata = vdata = 0, running = 0 throughout.
- Start and first line: assert en → first output (0,0) with frame_start = 1, de = 1. de falls at h = 640. hsync is low exactly for h = 656..751 (96 clocks). At h = 799→0: vdata = 1, line_start = 1.
- Full frame: run 420000 clocks → vsync low only on lines 490-491; de high exactly 307200 clocks; frame_start pulses once per frame, at clock 420000 after the first.
- Stop mid-frame: deassert en at (100,200) → counting continues to (799,524); the next clock gives idle outputs and running = 0.
- Stop then resume: deassert en at line 10 and reassert at line 20 → frame timing is identical to an uninterrupted run; running stays 1.
- Asynchronous reset mid-frame: pull rst_n low at (300,300) between clock edges → outputs go to idle values immediately. After release with en = 1, restart at (0,0) with frame_start = 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised raster timing generator with frame-aligned start/stop
module vga_timing_gen #(
    parameter int   WIDTH    = 10,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic [WIDTH-1:0] out_hdata,
    output logic [WIDTH-1:0] out_vdata,
    output logic             out_de,
    output logic             out_frame_start,
    output logic             out_line_start,
    output logic             out_running
);
    localparam logic [WIDTH-1:0] H_FP   = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] H_SP   = WIDTH'(H_ACTIVE + H_FRONT);
    localparam logic [WIDTH-1:0] H_BP   = WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [WIDTH-1:0] H_LAST = WIDTH'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [WIDTH-1:0] V_FP   = WIDTH'(V_ACTIVE);
    localparam logic [WIDTH-1:0] V_SP   = WIDTH'(V_ACTIVE + V_FRONT);
    localparam logic [WIDTH-1:0] V_BP   = WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [WIDTH-1:0] V_LAST = WIDTH'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} ctl_t;
    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

    ctl_t             ctl_q, ctl_d;
    phase_t           hph_q, hph_d, vph_q, vph_d;
    logic [WIDTH-1:0] h_q, h_d, v_q, v_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic             fs_q, fs_d, ls_q, ls_d, run_q, run_d;
    logic             wrap_h, wrap_f;

    // Next state: outputs are decoded from the next position so they register in step with it
    always_comb begin
        wrap_h  = h_q == H_LAST;
        wrap_f  = wrap_h && v_q == V_LAST;
        ctl_d   = en ? RUN : (ctl_q == IDLE || wrap_f) ? IDLE : STOPPING;
        run_d   = ctl_d != IDLE;
        h_d     = (!run_d || ctl_q == IDLE || wrap_h) ? '0 : h_q + 1'b1;
        v_d     = (!run_d || ctl_q == IDLE) ? '0 : !wrap_h ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
        hph_d   = h_d == '0 ? ACTIVE : h_d == H_FP ? FRONT : h_d == H_SP ? SYNC : h_d == H_BP ? BACK : hph_q;
        vph_d   = h_d != '0 ? vph_q : v_d == '0 ? ACTIVE : v_d == V_FP ? FRONT : v_d == V_SP ? SYNC : v_d == V_BP ? BACK : vph_q;
        hsync_d = (run_d && hph_d == SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync_d = (run_d && vph_d == SYNC) ? SYNC_POL : ~SYNC_POL;
        de_d    = run_d && hph_d == ACTIVE && vph_d == ACTIVE;
        ls_d    = run_d && h_d == '0;
        fs_d    = ls_d && v_d == '0;
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q   <= IDLE;
            hph_q   <= ACTIVE;
            vph_q   <= ACTIVE;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            ctl_q   <= ctl_d;
            hph_q   <= hph_d;
            vph_q   <= vph_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            run_q   <= run_d;
        end
    end

    assign out_hsync       = hsync_q;
    assign out_vsync       = vsync_q;
    assign out_hdata       = h_q;
    assign out_vdata       = v_q;
    assign out_de          = de_q;
    assign out_frame_start = fs_q;
    assign out_line_start  = ls_q;
    assign out_running     = run_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen on a reduced 15x10 raster
module tb_vga_timing_gen;
    localparam int W = 5, HA = 8, HF = 2, HS = 3, HB = 2, VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FRAME = HT * VT;

    logic         clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic         out_hsync, out_vsync, out_de, out_frame_start, out_line_start, out_running;
    logic [W-1:0] out_hdata, out_vdata;
    int           checks = 0, failures = 0;
    int           eh = 0, ev = 0, n, de_cnt, hs_cnt, vs_cnt, fs_cnt;
    bit           mrun = 0;

    vga_timing_gen #(.WIDTH(W), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                     .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_hdata(out_hdata), .out_vdata(out_vdata), .out_de(out_de),
        .out_frame_start(out_frame_start), .out_line_start(out_line_start), .out_running(out_running));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic hs, vs, de, ls, fs;
        hs = !(mrun && eh >= HA + HF && eh < HA + HF + HS);
        vs = !(mrun && ev >= VA + VF && ev < VA + VF + VS);
        de = mrun && eh < HA && ev < VA;
        ls = mrun && eh == 0;
        fs = ls && ev == 0;
        return {16'd0, hs, vs, de, fs, ls, mrun, W'(eh), W'(ev)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {16'd0, out_hsync, out_vsync, out_de, out_frame_start, out_line_start, out_running,
                out_hdata, out_vdata};
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        if (!mrun) begin
            if (en) begin mrun = 1; eh = 0; ev = 0; end
        end else if (!en && eh == HT - 1 && ev == VT - 1) begin
            mrun = 0; eh = 0; ev = 0;
        end else if (eh == HT - 1) begin
            eh = 0; ev = (ev == VT - 1) ? 0 : ev + 1;
        end else eh = eh + 1;
        @(negedge clk);
        check(tag, dut_vec(), exp_vec());
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        for (int k = 0; k < 1000 && !(eh == h && ev == v); k++) tick(tag);
        check({tag, "_reach"}, {eh[15:0], ev[15:0]}, {h[15:0], v[15:0]});
    endtask

    initial begin
        #12;
        check("reset_vec", dut_vec(), {16'd0, 6'b110000, 10'd0});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick("idle");
        en = 1'b1;
        tick("start");
        check("start_fs", out_frame_start, 1);
        check("start_de", out_de, 1);
        check("start_pos", {out_hdata, out_vdata}, 0);
        run_to(7, 0, "line0");
        check("de_h7", out_de, 1);
        tick("h8");
        check("de_h8", out_de, 0);
        run_to(0, 1, "wrap");
        check("wrap_ls", out_line_start, 1);
        check("wrap_v", out_vdata, 1);
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick("frame");
            de_cnt += int'(out_de);
            hs_cnt += int'(!out_hsync);
            vs_cnt += int'(!out_vsync);
            fs_cnt += int'(out_frame_start);
        end
        check("frame_de", de_cnt, HA * VA);
        check("frame_hs", hs_cnt, HS * VT);
        check("frame_vs", vs_cnt, VS * HT);
        check("frame_fs", fs_cnt, 1);
        run_to(5, 3, "pre_stop");
        en = 1'b0;
        n = 0;
        do begin tick("stop"); n++; end while (out_running && n < 400);
        check("stop_len", n, FRAME - (3 * HT + 5));
        for (int i = 0; i < 5; i++) tick("stopped");
        en = 1'b1;
        tick("restart");
        check("restart_fs", out_frame_start, 1);
        run_to(0, 2, "resume_a");
        en = 1'b0;
        run_to(0, 4, "resume_b");
        en = 1'b1;
        tick("resume_c");
        run_to(0, 0, "resume_d");
        check("resume_fs", out_frame_start, 1);
        check("resume_run", out_running, 1);
        run_to(3, 4, "pre_areset");
        #2 rst_n = 1'b0;
        #1;
        mrun = 0; eh = 0; ev = 0;
        check("areset_vec", dut_vec(), {16'd0, 6'b110000, 10'd0});
        @(negedge clk);
        check("areset_hold", dut_vec(), {16'd0, 6'b110000, 10'd0});
        rst_n = 1'b1;
        tick("after_reset");
        check("after_reset_fs", out_frame_start, 1);
        check("after_reset_pos", {out_hdata, out_vdata}, 0);
        for (int i = 0; i < 20; i++) tick("after_reset_run");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
